// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared constants and state type for the 32-way mux arbiter
package mux_arb_pkg;

  localparam int NREQ      = 32;
  localparam int SEL_W     = 5;
  localparam int MAX_BEATS = 16;
  localparam int CNT_W     = 8;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick_32.sv
// rtl/rr_pick_32.sv - combinational round-robin pick: first set req bit at or above ptr, wrapping
module rr_pick_32
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [SEL_W-1:0]  offset;

  // Rotating by ptr puts the highest-priority requester at bit 0.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr +: NREQ];

  always_comb begin
    offset = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) offset = SEL_W'(i);
    end
  end

  assign idx   = offset + ptr;
  assign found = |req;

endmodule

// File: rtl/mux_sel_rr_arbiter.sv
// rtl/mux_sel_rr_arbiter.sv - round-robin burst arbiter driving mux_nbit_32x1 select and output handshake
module mux_sel_rr_arbiter #(
  parameter int NREQ      = mux_arb_pkg::NREQ,
  parameter int SEL_W     = mux_arb_pkg::SEL_W,
  parameter int MAX_BEATS = mux_arb_pkg::MAX_BEATS,
  parameter int CNT_W     = mux_arb_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  last,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic             out_valid,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  ack,
  output logic             busy
);

  import mux_arb_pkg::arb_state_e;
  import mux_arb_pkg::ARB_IDLE;
  import mux_arb_pkg::ARB_GRANT;

  localparam logic [NREQ-1:0]  ONE_HOT0  = {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'((MAX_BEATS == 0) ? 0 : MAX_BEATS - 1);

  arb_state_e       state_q;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] sel_q;
  logic [NREQ-1:0]  gnt_q;
  logic [CNT_W-1:0] beat_cnt_q;

  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;
  logic             in_grant;
  logic             owner_req;
  logic             xfer;
  logic             limit_hit;
  logic             release_w;

  rr_pick_32 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign in_grant  = (state_q == ARB_GRANT);
  assign owner_req = req[sel_q];
  assign out_valid = in_grant & owner_req;
  assign xfer      = out_valid & out_ready;
  assign limit_hit = (MAX_BEATS != 0) && (beat_cnt_q == LAST_BEAT);
  // Withdrawal releases even without a transfer; out_ready only reaches state, never sel/gnt directly.
  assign release_w = in_grant & (~owner_req | (xfer & (last[sel_q] | limit_hit)));

  assign ack  = xfer ? gnt_q : '0;
  assign sel  = sel_q;
  assign gnt  = gnt_q;
  assign busy = in_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= '0;
      sel_q      <= '0;
      gnt_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_found) begin
            sel_q      <= pick_idx;
            gnt_q      <= ONE_HOT0 << pick_idx;
            beat_cnt_q <= '0;
            state_q    <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (xfer) beat_cnt_q <= beat_cnt_q + CNT_W'(1);
          if (release_w) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            ptr_q   <= sel_q + SEL_W'(1);
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// tb/tb_mux_sel_rr_arbiter.sv - directed self-checking bench for mux_sel_rr_arbiter
module tb_mux_sel_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] req;
  logic [31:0] last;
  logic        out_ready;
  logic [4:0]  sel;
  logic        out_valid;
  logic [31:0] gnt;
  logic [31:0] ack;
  logic        busy;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mux_sel_rr_arbiter #(.NREQ(32), .SEL_W(5), .MAX_BEATS(16), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .last      (last),
    .out_ready (out_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .gnt       (gnt),
    .ack       (ack),
    .busy      (busy)
  );

  task automatic drive(input logic [31:0] r, input logic [31:0] l, input logic rd);
    @(negedge clk);
    req = r; last = l; out_ready = rd;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; last = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    drive(32'h0, 32'h0, 1'b1);
    checks++; if (gnt !== 32'h0) begin fails++; $display("FAIL rst_gnt: got %h want %h", gnt, 32'h0); end
    checks++; if (sel !== 5'd0) begin fails++; $display("FAIL rst_sel: got %0d want 0", sel); end
    checks++; if (out_valid !== 1'b0 || ack !== 32'h0 || busy !== 1'b0) begin
      fails++; $display("FAIL rst_outs: valid %b ack %h busy %b want 0 0 0", out_valid, ack, busy); end
  endtask

  task automatic test_single_burst();
    do_reset();
    drive(32'h1, 32'h0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sb_idle_valid: got %b want 0", out_valid); end
    for (int b = 1; b <= 3; b++) begin
      drive(32'h1, (b == 3) ? 32'h1 : 32'h0, 1'b1);
      checks++; if (sel !== 5'd0 || out_valid !== 1'b1) begin
        fails++; $display("FAIL sb_beat%0d: sel %0d valid %b want 0 1", b, sel, out_valid); end
      checks++; if (ack !== 32'h1) begin fails++; $display("FAIL sb_ack%0d: got %h want %h", b, ack, 32'h1); end
    end
    drive(32'hFFFF_FFFF, 32'h0, 1'b1);
    checks++; if (gnt !== 32'h0 || busy !== 1'b0 || ack !== 32'h0) begin
      fails++; $display("FAIL sb_release: gnt %h busy %b ack %h want 0 0 0", gnt, busy, ack); end
    drive(32'h0, 32'h0, 1'b1);
    checks++; if (gnt !== 32'h2 || sel !== 5'd1) begin
      fails++; $display("FAIL sb_ptr1: gnt %h sel %0d want 00000002 1", gnt, sel); end
  endtask

  task automatic test_alternate_wrap();
    logic [31:0] exp_gnt;
    logic [4:0]  exp_sel;
    do_reset();
    drive(32'h8000_0001, 32'hFFFF_FFFF, 1'b1);
    for (int g = 0; g < 4; g++) begin
      exp_sel = (g % 2 == 0) ? 5'd0 : 5'd31;
      exp_gnt = (g % 2 == 0) ? 32'h0000_0001 : 32'h8000_0000;
      drive(32'h8000_0001, 32'hFFFF_FFFF, 1'b1);
      checks++; if (gnt !== exp_gnt || sel !== exp_sel) begin
        fails++; $display("FAIL alt_grant%0d: gnt %h sel %0d want %h %0d", g, gnt, sel, exp_gnt, exp_sel); end
      checks++; if (ack !== exp_gnt) begin fails++; $display("FAIL alt_ack%0d: got %h want %h", g, ack, exp_gnt); end
      drive(32'h8000_0001, 32'hFFFF_FFFF, 1'b1);
      checks++; if (gnt !== 32'h0 || out_valid !== 1'b0 || sel !== exp_sel) begin
        fails++; $display("FAIL alt_bubble%0d: gnt %h valid %b sel %0d want 0 0 %0d", g, gnt, out_valid, sel, exp_sel); end
    end
  endtask

  task automatic test_beat_limit();
    int acks;
    bit done;
    do_reset();
    drive(32'h0000_0060, 32'h0, 1'b1);
    acks = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      drive(32'h0000_0060, 32'h0, 1'b1);
      if (gnt === 32'h0) done = 1;
      else if (ack === 32'h0000_0020) acks++;
      else begin
        checks++; fails++; $display("FAIL lim_ack: got %h want %h", ack, 32'h0000_0020);
      end
    end
    checks++; if (!done) begin fails++; $display("FAIL lim_release: got no release want release"); end
    checks++; if (acks != 16) begin fails++; $display("FAIL lim_count: got %0d want 16", acks); end
    drive(32'h0000_0060, 32'h0, 1'b0);
    checks++; if (gnt !== 32'h0000_0040 || sel !== 5'd6) begin
      fails++; $display("FAIL lim_next: gnt %h sel %0d want 00000040 6", gnt, sel); end
  endtask

  task automatic test_backpressure();
    int acks;
    bit done;
    do_reset();
    drive(32'h0000_0080, 32'h0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      drive(32'h0000_0080, 32'h0, 1'b0);
      checks++; if (out_valid !== 1'b1 || ack !== 32'h0 || sel !== 5'd7) begin
        fails++; $display("FAIL bp_stall%0d: valid %b ack %h sel %0d want 1 0 7", c, out_valid, ack, sel); end
    end
    acks = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      drive(32'h0000_0080, 32'h0, 1'b1);
      if (gnt === 32'h0) done = 1;
      else if (ack === 32'h0000_0080) acks++;
    end
    checks++; if (acks != 16) begin fails++; $display("FAIL bp_count: got %0d want 16", acks); end
  endtask

  task automatic test_withdraw();
    do_reset();
    drive(32'h0000_0008, 32'h0, 1'b1);
    for (int b = 0; b < 2; b++) begin
      drive(32'h0000_0008, 32'h0, 1'b1);
      checks++; if (ack !== 32'h0000_0008) begin fails++; $display("FAIL wd_ack%0d: got %h want %h", b, ack, 32'h8); end
    end
    drive(32'h0, 32'h0, 1'b1);
    checks++; if (out_valid !== 1'b0 || ack !== 32'h0 || busy !== 1'b1) begin
      fails++; $display("FAIL wd_drop: valid %b ack %h busy %b want 0 0 1", out_valid, ack, busy); end
    drive(32'h0000_0018, 32'h0, 1'b0);
    checks++; if (gnt !== 32'h0) begin fails++; $display("FAIL wd_bubble: got %h want 0", gnt); end
    drive(32'h0000_0018, 32'h0, 1'b0);
    checks++; if (gnt !== 32'h0000_0010 || sel !== 5'd4) begin
      fails++; $display("FAIL wd_ptr4: gnt %h sel %0d want 00000010 4", gnt, sel); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(32'h0000_0200, 32'h0, 1'b1);
    drive(32'h0000_0200, 32'h0, 1'b1);
    checks++; if (ack !== 32'h0000_0200 || sel !== 5'd9) begin
      fails++; $display("FAIL ar_pre: ack %h sel %0d want 00000200 9", ack, sel); end
    req = 32'hFFFF_FFFF;
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (gnt !== 32'h0 || out_valid !== 1'b0 || ack !== 32'h0 || sel !== 5'd0) begin
      fails++; $display("FAIL ar_now: gnt %h valid %b ack %h sel %0d want 0 0 0 0", gnt, out_valid, ack, sel); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'hFFFF_FFFF, 32'h0, 1'b1);
    checks++; if (gnt !== 32'h0000_0001 || sel !== 5'd0) begin
      fails++; $display("FAIL ar_restart: gnt %h sel %0d want 00000001 0", gnt, sel); end
    drive(32'h0, 32'h0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_burst();
    test_alternate_wrap();
    test_beat_limit();
    test_backpressure();
    test_withdraw();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
